axil_regfile: RTL and testbench

AXI-Lite slave register bank that sits directly downstream of the core-to-AXI bridge on the ethernet SoC interconnect. It accepts single-beat AXI-Lite write and read transactions, decodes them against a base address and drives a bank of 32-bit control registers. It also exposes one read-only status word to the core. Every transaction completes with an OKAY or SLVERR response.

---
 rtl/axil_regfile.sv | 197 +++++++++++++++++++
 tb/tb_axil_regfile.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile.sv
// axil_regfile: AXI-Lite slave register bank. N_REGS read/write control
// registers decoded from BASE_ADDR, plus one read-only status word at index 15.
// Single-beat transactions only; every transaction gets OKAY or SLVERR.
module axil_regfile #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          N_REGS    = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [31:0]           araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [32*N_REGS-1:0]  ctrl_regs,
    input  logic [31:0]           status_in
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [4:0] N_REGS_W    = 5'(N_REGS);
    localparam logic [3:0] STATUS_IDX  = 4'd15;

    // Returns {hit, idx}: hit means inside the 64-byte window and word aligned.
    function automatic logic [4:0] decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return {(off < 32'd64) && (off[1:0] == 2'b00), off[5:2]};
    endfunction

    logic        ready_en_q, ready_en_d;
    logic        aw_held_q, aw_held_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] regs_q [N_REGS];
    logic [31:0] regs_d [N_REGS];

    logic        aw_accept, w_accept, ar_accept, commit;
    logic [4:0]  wr_dec, rd_dec;
    logic        wr_reg_ok;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Readies are held low until the first edge after reset so that every
    // ready output reads 0 while resetn is asserted.
    assign awready = ready_en_q && !aw_held_q && !bvalid_q;
    assign wready  = ready_en_q && !w_held_q && !bvalid_q;
    assign arready = ready_en_q && !rvalid_q;

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    assign aw_accept = awvalid && awready;
    // wlast carries no information for single-beat transfers; the tautology
    // only keeps the port referenced.
    assign w_accept  = wvalid && wready && (wlast || !wlast);
    assign ar_accept = arvalid && arready;
    assign commit    = aw_held_q && w_held_q && !bvalid_q;

    assign wr_dec    = decode(awaddr_q);
    assign wr_reg_ok = wr_dec[4] && ({1'b0, wr_dec[3:0]} < N_REGS_W);
    assign rd_dec    = decode(araddr);

    // Write path: channel holding registers, commit with byte strobes, B response.
    always_comb begin
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        if (aw_accept) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (w_accept) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_reg_ok ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < N_REGS; k++) begin
                if (wr_reg_ok && (wr_dec[3:0] == 4'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path: select the addressed word and register it on AR acceptance.
    always_comb begin
        rd_data  = 32'hDEAD_BEEF;
        rd_resp  = RESP_SLVERR;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rd_dec[4]) begin
            if (rd_dec[3:0] == STATUS_IDX) begin
                rd_data = status_in;
                rd_resp = RESP_OKAY;
            end else begin
                for (int k = 0; k < N_REGS; k++) begin
                    if (rd_dec[3:0] == 4'(k)) begin
                        rd_data = regs_q[k];
                        rd_resp = RESP_OKAY;
                    end
                end
            end
        end
        if (ar_accept) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_resp;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Flatten the register array onto the ctrl_regs bus.
    always_comb begin
        ctrl_regs = '0;
        for (int k = 0; k < N_REGS; k++) begin
            ctrl_regs[32*k +: 32] = regs_q[k];
        end
    end

    // State registers; reset drops any transaction in flight without a response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            ready_en_q <= ready_en_d;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

endmodule

// File: tb/tb_axil_regfile.sv
// Bench for axil_regfile: B and R responses are checked against a scoreboard
// filled when each transaction is issued; latencies, stalls and ctrl_regs are
// checked directly against a small register model.
module tb_axil_regfile;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          N    = 8;
    localparam logic [31:0] RV   = 32'h1234_5678;

    logic            clk;
    logic            resetn;
    logic [31:0]     awaddr;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [31:0]     araddr;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [32*N-1:0] ctrl_regs;
    logic [31:0]     status_in;

    axil_regfile #(.BASE_ADDR(BASE), .N_REGS(N), .RESET_VAL(RV)) dut (
        .clk(clk), .resetn(resetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ctrl_regs(ctrl_regs), .status_in(status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];
    logic [31:0] mdl [N];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic wr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off < 32'(4 * N)) && (off[1:0] == 2'b00);
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] addr, input logic [31:0] st);
        logic [31:0] off;
        off = addr - BASE;
        if ((off < 32'(4 * N)) && (off[1:0] == 2'b00)) return {2'b00, mdl[int'(off >> 2)]};
        if (off == 32'd60) return {2'b00, st};
        return {2'b10, 32'hDEAD_BEEF};
    endfunction

    function automatic void mdl_write(input logic [31:0] addr, input logic [31:0] d,
                                      input logic [3:0] s);
        int i;
        if (!wr_ok(addr)) return;
        i = int'((addr - BASE) >> 2);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic check_ctrl(input string tag);
        for (int k = 0; k < N; k++)
            check_val($sformatf("%s_ctrl%0d", tag, k), 64'(ctrl_regs[32*k +: 32]), 64'(mdl[k]));
    endtask

    // Response monitor: pops the scoreboard at every B/R handshake.
    always @(negedge clk) begin
        if (resetn && bvalid && bready) begin
            if (b_q.size() == 0) check_val("b_unexpected", 64'(b_q.size()), 64'd1);
            else check_val("bresp", 64'(bresp), 64'(b_q.pop_front()));
        end
        if (resetn && rvalid && rready) begin
            if (r_q.size() == 0) check_val("r_unexpected", 64'(r_q.size()), 64'd1);
            else check_val("rresp_rdata", 64'({rresp, rdata}), 64'(r_q.pop_front()));
        end
    end

    task automatic idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // AW and W together; returns just after the commit edge.
    task automatic write_both(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        b_q.push_back(wr_ok(addr) ? 2'b00 : 2'b10);
        awaddr = addr; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready && wready) begin got = 1; break; end
        end
        if (!got) check_val("aw_w_accept", 64'({awready, wready}), 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("b_not_yet", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        check_val("b_latency", 64'(bvalid), 64'd1);
        mdl_write(addr, d, s);
        check_ctrl("wr");
    endtask

    task automatic read_txn(input logic [31:0] addr);
        bit got = 0;
        r_q.push_back(exp_read(addr, status_in));
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin got = 1; break; end
        end
        if (!got) check_val("ar_accept", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_val("r_latency", 64'(rvalid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        resetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status_in = '0;
        for (int k = 0; k < N; k++) mdl[k] = RV;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        check_ctrl("rst_init");

        // Reset mid-transaction: a write to reg3, then an AW held and a read pending.
        write_both(BASE + 32'hC, 32'h1111_2222, 4'hF);
        idle();
        rready = 1'b0;
        awaddr = BASE; awvalid = 1'b1; araddr = BASE + 32'h4; arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        for (int k = 0; k < N; k++) mdl[k] = RV;
        check_val("rst_awready", 64'(awready), 64'd0);
        check_val("rst_wready", 64'(wready), 64'd0);
        check_val("rst_arready", 64'(arready), 64'd0);
        check_val("rst_bvalid", 64'(bvalid), 64'd0);
        check_val("rst_rvalid", 64'(rvalid), 64'd0);
        check_val("rst_rdata", 64'(rdata), 64'd0);
        check_ctrl("rst_async");
        @(posedge clk); #1;
        resetn = 1'b1; rready = 1'b1;
        @(posedge clk); #1;

        // Write then read reg2.
        write_both(BASE + 32'h8, 32'hCAFE_F00D, 4'hF);
        idle();
        read_txn(BASE + 32'h8);

        // Strobes, W three cycles ahead of AW.
        write_both(BASE, 32'h0, 4'hF);
        idle();
        b_q.push_back(2'b00);
        wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin got = 1; break; end
        end
        if (!got) check_val("strb_w_accept", 64'(wready), 64'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        awaddr = BASE; awvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin got = 1; break; end
        end
        if (!got) check_val("strb_aw_accept", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check_val("strb_b_early", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        check_val("strb_b_lat", 64'(bvalid), 64'd1);
        mdl[0] = 32'h00BB_00DD;
        check_ctrl("strb");
        idle();

        // Error decode cases.
        write_both(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
        idle();
        status_in = 32'h0000_00A5;
        read_txn(BASE + 32'h3C);
        read_txn(BASE + 32'h20);
        read_txn(BASE + 32'h2);
        read_txn(BASE - 32'h4);
        write_both(BASE + 32'h24, 32'h7777_7777, 4'hF);
        idle();
        write_both(BASE + 32'h1C, 32'h0BAD_F00D, 4'h0);
        idle();

        // Backpressure on B with a second write waiting.
        bready = 1'b0;
        write_both(BASE + 32'h10, 32'h5555_AAAA, 4'hF);
        b_q.push_back(2'b00);
        awaddr = BASE + 32'h14; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_bvalid", 64'(bvalid), 64'd1);
            check_val("bp_bresp", 64'(bresp), 64'd0);
            check_val("bp_awready", 64'(awready), 64'd0);
            check_val("bp_wready", 64'(wready), 64'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        check_val("bp_hs_awready", 64'(awready), 64'd0);
        @(negedge clk);
        check_val("bp_accept", 64'({awready, wready}), 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("bp2_b_early", 64'(bvalid), 64'd0);
        @(posedge clk); #1;
        check_val("bp2_b_lat", 64'(bvalid), 64'd1);
        mdl_write(BASE + 32'h14, 32'h0F0F_0F0F, 4'hF);
        check_ctrl("bp2");
        idle();

        // Read accepted on the same edge as a write commit to that register.
        write_both(BASE + 32'h4, 32'h0, 4'hF);
        idle();
        b_q.push_back(2'b00);
        r_q.push_back(exp_read(BASE + 32'h4, status_in));
        awaddr = BASE + 32'h4; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check_val("col_aw_w_ready", 64'({awready, wready}), 64'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 32'h4; arvalid = 1'b1;
        @(negedge clk);
        check_val("col_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_val("col_bvalid", 64'(bvalid), 64'd1);
        check_val("col_rvalid", 64'(rvalid), 64'd1);
        mdl[1] = 32'h1;
        check_ctrl("col");
        @(posedge clk); #1;
        read_txn(BASE + 32'h4);
        idle();

        check_val("b_sb_left", 64'(b_q.size()), 64'd0);
        check_val("r_sb_left", 64'(r_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
